// File: rtl/lh_pkg.sv
// Shared widths, FSM encoding and sample payload for the lighthouse sample arbiter.
package lh_pkg;

    localparam int unsigned LH_DATA_W = 32;
    localparam int unsigned LH_ADDR_W = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } lh_state_e;

    typedef struct packed {
        logic [LH_ADDR_W-1:0] addr;
        logic [LH_DATA_W-1:0] data;
    } lh_sample_t;

    // Index width for n channels; a single channel still gets a 1-bit index.
    function automatic int unsigned lh_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lh_rr_pick.sv
// Combinational round-robin picker: first pending index at or after rr_ptr, wrapping.
module lh_rr_pick
#(
    parameter int unsigned NUM_SENSORS = 4,
    parameter int unsigned IDX_W       = 2
) (
    input  logic [NUM_SENSORS-1:0] pending,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic [IDX_W-1:0]       grant,
    output logic                   any_pending
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = '0;
        any_pending = 1'b0;
        for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_SENSORS;
            if (!any_pending && pending[IDX_W'(idx)]) begin
                grant       = IDX_W'(idx);
                any_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lh_sample_arbiter.sv
// Serialises per-sensor sweep samples onto one valid/ready stream with round-robin grant.
// Optional capture timestamps are enabled by defining LH_ARB_TIMESTAMP_EN.
module lh_sample_arbiter
    import lh_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = 4,
    parameter int unsigned TS_WIDTH    = 32
) (
    input  logic                                 CLK,
    input  logic                                 RESET,
    input  logic [NUM_SENSORS-1:0]               SENSOR_READY,
    input  logic [LH_ADDR_W*NUM_SENSORS-1:0]     SENSOR_ADDRESS,
    input  logic [LH_DATA_W*NUM_SENSORS-1:0]     SENSOR_DATA,
    output logic                                 OUT_VALID,
    input  logic                                 OUT_READY,
    output logic [lh_idx_w(NUM_SENSORS)-1:0]     OUT_SENSOR,
    output logic [LH_ADDR_W-1:0]                 OUT_ADDRESS,
    output logic [LH_DATA_W-1:0]                 OUT_DATA,
    output logic [NUM_SENSORS-1:0]               OVERFLOW,
    input  logic                                 OVF_CLR
`ifdef LH_ARB_TIMESTAMP_EN
    ,
    output logic [TS_WIDTH-1:0]                  OUT_TIMESTAMP
`endif
);

    localparam int unsigned IDX_W = lh_idx_w(NUM_SENSORS);

    if (NUM_SENSORS < 1 || NUM_SENSORS > 16 || TS_WIDTH < 1) begin : g_bad_cfg
        $error("lh_sample_arbiter: unsupported NUM_SENSORS or TS_WIDTH");
    end

    lh_state_e              state;
    logic [NUM_SENSORS-1:0] ready_q;
    logic [NUM_SENSORS-1:0] pending;
    logic [NUM_SENSORS-1:0] rise;
    logic [NUM_SENSORS-1:0] grant_clr;
    logic [NUM_SENSORS-1:0] ovf_set;
    lh_sample_t             slot [NUM_SENSORS];
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       next_ptr;
    logic                   any_pending;
    logic                   grant_now;

`ifdef LH_ARB_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    ts_cnt;
    logic [TS_WIDTH-1:0]    slot_ts [NUM_SENSORS];
`endif

    lh_rr_pick #(
        .NUM_SENSORS (NUM_SENSORS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .pending     (pending),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .any_pending (any_pending)
    );

    // A slot granted this cycle is not an overrun target, even if its sensor rises now.
    always_comb begin
        rise      = SENSOR_READY & ~ready_q;
        grant_now = (state == ST_IDLE) && any_pending;
        grant_clr = '0;
        if (grant_now) begin
            grant_clr = NUM_SENSORS'(1) << grant;
        end
        ovf_set  = rise & pending & ~grant_clr;
        next_ptr = (OUT_SENSOR == IDX_W'(NUM_SENSORS - 1)) ? '0 : OUT_SENSOR + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            ready_q     <= '0;
            pending     <= '0;
            rr_ptr      <= '0;
            OUT_VALID   <= 1'b0;
            OUT_SENSOR  <= '0;
            OUT_ADDRESS <= '0;
            OUT_DATA    <= '0;
            OVERFLOW    <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                slot[i] <= '0;
            end
`ifdef LH_ARB_TIMESTAMP_EN
            ts_cnt        <= '0;
            OUT_TIMESTAMP <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                slot_ts[i] <= '0;
            end
`endif
        end else begin
            ready_q  <= SENSOR_READY;
            pending  <= (pending & ~grant_clr) | rise;
            OVERFLOW <= (OVF_CLR ? '0 : OVERFLOW) | ovf_set;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (rise[i]) begin
                    slot[i].addr <= SENSOR_ADDRESS[LH_ADDR_W*i +: LH_ADDR_W];
                    slot[i].data <= SENSOR_DATA[LH_DATA_W*i +: LH_DATA_W];
                end
            end
`ifdef LH_ARB_TIMESTAMP_EN
            ts_cnt <= ts_cnt + 1'b1;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (rise[i]) begin
                    slot_ts[i] <= ts_cnt;
                end
            end
`endif
            case (state)
                ST_IDLE: begin
                    if (any_pending) begin
                        OUT_VALID   <= 1'b1;
                        OUT_SENSOR  <= grant;
                        OUT_ADDRESS <= slot[grant].addr;
                        OUT_DATA    <= slot[grant].data;
`ifdef LH_ARB_TIMESTAMP_EN
                        OUT_TIMESTAMP <= slot_ts[grant];
`endif
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        rr_ptr    <= next_ptr;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
